// File: rtl/crtc_dmac_pkg.sv
// Shared definitions for the CRTC row-fetch DMA controller:
// register selects, mode/status bit positions and FSM state encoding.
package crtc_dmac_pkg;

    localparam logic [1:0] REG_ADR  = 2'd0;
    localparam logic [1:0] REG_CNT  = 2'd1;
    localparam logic [1:0] REG_MODE = 2'd2;

    localparam int MODE_EN_BIT     = 0;
    localparam int MODE_AUTO_BIT   = 7;
    localparam int STAT_BUSREQ_BIT = 0;
    localparam int STAT_TC_BIT     = 3;
    localparam int STAT_EN_BIT     = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_ADDR = 2'd2,
        ST_XFER = 2'd3
    } state_e;

endpackage

// File: rtl/crtc_dmac_regs.sv
// CPU-visible register file: base address/count behind a shared byte pointer,
// mode register, sticky TC flag with read-to-clear, and enable rising-edge detect.
module crtc_dmac_regs
    import crtc_dmac_pkg::*;
#(
    parameter int ADR_W = 16,
    parameter int CNT_W = 14
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             io_we,
    input  logic             io_re,
    input  logic [1:0]       io_adr,
    input  logic [7:0]       io_wdata,
    output logic [7:0]       io_rdata,
    input  logic             busreq,
    input  logic             tc_set,
    input  logic             en_clr,
    input  logic [ADR_W-1:0] cur_adr,
    input  logic [CNT_W-1:0] cur_cnt,
    output logic [ADR_W-1:0] base_adr,
    output logic [CNT_W-1:0] base_cnt,
    output logic             enable,
    output logic             autoload,
    output logic             en_rise
);

    logic [ADR_W-1:0] base_adr_q, base_adr_d;
    logic [CNT_W-1:0] base_cnt_q, base_cnt_d;
    logic             byte_ff_q, byte_ff_d;
    logic             enable_q, enable_d;
    logic             autoload_q, autoload_d;
    logic             tc_flag_q, tc_flag_d;
    logic [7:0]       io_rdata_q, io_rdata_d;

    logic        ptr_acc;
    logic        wr_mode;
    logic        rd_mode;
    logic [15:0] cur_adr16;
    logic [15:0] cur_cnt16;

    assign cur_adr16 = 16'(cur_adr);
    assign cur_cnt16 = 16'(cur_cnt);

    assign ptr_acc = (io_we | io_re) & ((io_adr == REG_ADR) | (io_adr == REG_CNT));
    assign wr_mode = io_we & (io_adr == REG_MODE);
    assign rd_mode = io_re & (io_adr == REG_MODE);
    assign en_rise = wr_mode & io_wdata[MODE_EN_BIT] & ~enable_q;

    always_comb begin
        base_adr_d = base_adr_q;
        base_cnt_d = base_cnt_q;
        byte_ff_d  = byte_ff_q;
        enable_d   = enable_q;
        autoload_d = autoload_q;
        tc_flag_d  = tc_flag_q;
        io_rdata_d = io_rdata_q;

        if (io_we && io_adr == REG_ADR) begin
            if (byte_ff_q) base_adr_d[ADR_W-1:8] = io_wdata[ADR_W-9:0];
            else           base_adr_d[7:0]       = io_wdata;
        end
        // Upper count byte keeps only the bits that fit the count field.
        if (io_we && io_adr == REG_CNT) begin
            if (byte_ff_q) base_cnt_d[CNT_W-1:8] = io_wdata[CNT_W-9:0];
            else           base_cnt_d[7:0]       = io_wdata;
        end

        if (ptr_acc) byte_ff_d = ~byte_ff_q;

        if (wr_mode) begin
            byte_ff_d  = 1'b0;
            enable_d   = io_wdata[MODE_EN_BIT];
            autoload_d = io_wdata[MODE_AUTO_BIT];
        end else if (en_clr) begin
            enable_d = 1'b0;
        end

        if (io_re) begin
            case (io_adr)
                REG_ADR:  io_rdata_d = byte_ff_q ? cur_adr16[15:8] : cur_adr16[7:0];
                REG_CNT:  io_rdata_d = byte_ff_q ? cur_cnt16[15:8] : cur_cnt16[7:0];
                REG_MODE: begin
                    io_rdata_d                  = 8'h00;
                    io_rdata_d[STAT_TC_BIT]     = tc_flag_q;
                    io_rdata_d[STAT_EN_BIT]     = enable_q;
                    io_rdata_d[STAT_BUSREQ_BIT] = busreq;
                end
                default:  io_rdata_d = 8'h00;
            endcase
        end

        // A terminal count landing on the clearing read wins.
        if (tc_set)       tc_flag_d = 1'b1;
        else if (rd_mode) tc_flag_d = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            base_adr_q <= '0;
            base_cnt_q <= '0;
            byte_ff_q  <= 1'b0;
            enable_q   <= 1'b0;
            autoload_q <= 1'b0;
            tc_flag_q  <= 1'b0;
            io_rdata_q <= 8'h00;
        end else begin
            base_adr_q <= base_adr_d;
            base_cnt_q <= base_cnt_d;
            byte_ff_q  <= byte_ff_d;
            enable_q   <= enable_d;
            autoload_q <= autoload_d;
            tc_flag_q  <= tc_flag_d;
            io_rdata_q <= io_rdata_d;
        end
    end

    assign base_adr = base_adr_q;
    assign base_cnt = base_cnt_q;
    assign enable   = enable_q;
    assign autoload = autoload_q;
    assign io_rdata = io_rdata_q;

endmodule

// File: rtl/crtc_dmac.sv
// Single-channel DMA for CRTC character-row fetch: bus handshake FSM,
// current address/count, and autoload at terminal count.
//
//   state   | meaning
//   IDLE    | no bus ownership, waiting for enable & drq
//   REQ     | busreq raised, waiting for busack
//   ADDR    | ram_adr driven, waiting RD_LAT cycles for read data
//   XFER    | dack (and tc on last byte), advance address/count
module crtc_dmac
    import crtc_dmac_pkg::*;
#(
    parameter int ADR_W  = 16,
    parameter int CNT_W  = 14,
    parameter int RD_LAT = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             io_we,
    input  logic             io_re,
    input  logic [1:0]       io_adr,
    input  logic [7:0]       io_wdata,
    output logic [7:0]       io_rdata,
    input  logic             drq,
    output logic             dack,
    output logic             tc,
    output logic             busreq,
    input  logic             busack,
    output logic [ADR_W-1:0] ram_adr,
    input  logic [7:0]       ram_data_in,
    output logic [7:0]       ram_data_out
);

    localparam logic [1:0] LAT_LOAD = 2'(RD_LAT - 1);

    state_e           state_q, state_d;
    logic [1:0]       lat_q, lat_d;
    logic             busreq_q, busreq_d;
    logic             dack_q, dack_d;
    logic             tc_q, tc_d;
    logic [ADR_W-1:0] cur_adr_q, cur_adr_d;
    logic [CNT_W-1:0] cur_cnt_q, cur_cnt_d;

    logic [ADR_W-1:0] base_adr;
    logic [CNT_W-1:0] base_cnt;
    logic             enable;
    logic             autoload;
    logic             en_rise;
    logic             tc_set;
    logic             en_clr;

    assign tc_set = (state_q == ST_XFER) & tc_q;
    assign en_clr = tc_set & ~autoload;

    crtc_dmac_regs #(
        .ADR_W (ADR_W),
        .CNT_W (CNT_W)
    ) u_regs (
        .clk      (clk),
        .reset_n  (reset_n),
        .io_we    (io_we),
        .io_re    (io_re),
        .io_adr   (io_adr),
        .io_wdata (io_wdata),
        .io_rdata (io_rdata),
        .busreq   (busreq_q),
        .tc_set   (tc_set),
        .en_clr   (en_clr),
        .cur_adr  (cur_adr_q),
        .cur_cnt  (cur_cnt_q),
        .base_adr (base_adr),
        .base_cnt (base_cnt),
        .enable   (enable),
        .autoload (autoload),
        .en_rise  (en_rise)
    );

    always_comb begin
        state_d   = state_q;
        lat_d     = lat_q;
        dack_d    = 1'b0;
        tc_d      = 1'b0;
        cur_adr_d = cur_adr_q;
        cur_cnt_d = cur_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (enable && drq) state_d = ST_REQ;
            end
            ST_REQ: begin
                if (!enable || !drq) begin
                    state_d = ST_IDLE;
                end else if (busack) begin
                    state_d = ST_ADDR;
                    lat_d   = LAT_LOAD;
                end
            end
            ST_ADDR: begin
                // Losing the grant abandons this fetch; the same byte is retried.
                if (!busack) begin
                    state_d = ST_REQ;
                end else if (lat_q == 2'd0) begin
                    state_d = ST_XFER;
                    dack_d  = 1'b1;
                    tc_d    = (cur_cnt_q == '0);
                end else begin
                    lat_d = lat_q - 2'd1;
                end
            end
            ST_XFER: begin
                cur_adr_d = cur_adr_q + ADR_W'(1);
                cur_cnt_d = cur_cnt_q - CNT_W'(1);
                if (tc_q) begin
                    state_d = ST_IDLE;
                    if (autoload) begin
                        cur_adr_d = base_adr;
                        cur_cnt_d = base_cnt;
                    end
                end else if (drq && enable && busack) begin
                    state_d = ST_ADDR;
                    lat_d   = LAT_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (en_rise) begin
            cur_adr_d = base_adr;
            cur_cnt_d = base_cnt;
        end

        busreq_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            lat_q     <= 2'd0;
            busreq_q  <= 1'b0;
            dack_q    <= 1'b0;
            tc_q      <= 1'b0;
            cur_adr_q <= '0;
            cur_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            lat_q     <= lat_d;
            busreq_q  <= busreq_d;
            dack_q    <= dack_d;
            tc_q      <= tc_d;
            cur_adr_q <= cur_adr_d;
            cur_cnt_q <= cur_cnt_d;
        end
    end

    assign busreq       = busreq_q;
    assign dack         = dack_q;
    assign tc           = tc_q;
    assign ram_adr      = cur_adr_q;
    assign ram_data_out = dack_q ? ram_data_in : 8'h00;

endmodule

// File: tb/tb_crtc_dmac.sv
// Scoreboard bench for crtc_dmac: expected bytes are queued when a transfer
// is started and a negedge monitor checks every dack against the queue.
module tb_crtc_dmac;

    localparam int RD_LAT = 1;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        io_we = 1'b0;
    logic        io_re = 1'b0;
    logic [1:0]  io_adr = 2'd0;
    logic [7:0]  io_wdata = 8'h00;
    logic [7:0]  io_rdata;
    logic        drq = 1'b0;
    logic        dack;
    logic        tc;
    logic        busreq;
    logic        busack;
    logic [15:0] ram_adr;
    logic [7:0]  ram_data_in;
    logic [7:0]  ram_data_out;

    logic        bus_hold = 1'b0;
    logic        stall_en = 1'b0;
    logic        stall_rand = 1'b0;

    int checks = 0;
    int errors = 0;
    int dack_cnt = 0;

    typedef struct {
        logic [15:0] adr;
        logic [7:0]  data;
        logic        tc;
    } exp_t;
    exp_t sb[$];

    logic [7:0] mem [0:65535];
    logic [7:0] pipe [RD_LAT];

    always #5 clk = ~clk;

    assign busack = busreq & ~bus_hold & ~stall_rand;

    crtc_dmac #(.ADR_W(16), .CNT_W(14), .RD_LAT(RD_LAT)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .io_we        (io_we),
        .io_re        (io_re),
        .io_adr       (io_adr),
        .io_wdata     (io_wdata),
        .io_rdata     (io_rdata),
        .drq          (drq),
        .dack         (dack),
        .tc           (tc),
        .busreq       (busreq),
        .busack       (busack),
        .ram_adr      (ram_adr),
        .ram_data_in  (ram_data_in),
        .ram_data_out (ram_data_out)
    );

    // Synchronous RAM with RD_LAT cycles of read latency.
    always @(posedge clk) begin
        pipe[0] <= mem[ram_adr];
        for (int k = 1; k < RD_LAT; k++) pipe[k] <= pipe[k-1];
    end
    assign ram_data_in = pipe[RD_LAT-1];

    always @(negedge clk) stall_rand = stall_en ? ($urandom_range(0, 3) == 0) : 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            if (tc && !dack) chk("tc_without_dack", 32'(tc), 32'd0);
            if (dack) begin
                exp_t e;
                dack_cnt++;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_dack: got adr %0h expected no transfer", ram_adr);
                end else begin
                    e = sb.pop_front();
                    chk("dack_adr", 32'(ram_adr), 32'(e.adr));
                    chk("dack_data", 32'(ram_data_out), 32'(e.data));
                    chk("dack_tc", 32'(tc), 32'(e.tc));
                end
            end
        end
    end

    // Reference: a frame of (count+1) bytes starting at base, wrapping at 64K.
    task automatic push_range(input logic [15:0] base, input int total, input int from, input int upto);
        exp_t e;
        for (int i = from; i < upto; i++) begin
            e.adr  = 16'((int'(base) + i) % 65536);
            e.data = mem[e.adr];
            e.tc   = (i == total - 1);
            sb.push_back(e);
        end
    endtask

    task automatic io_wr(input logic [1:0] a, input logic [7:0] d);
        @(negedge clk);
        io_we = 1'b1; io_adr = a; io_wdata = d;
        @(negedge clk);
        io_we = 1'b0;
    endtask

    task automatic io_rd(input logic [1:0] a, output logic [7:0] d);
        @(negedge clk);
        io_re = 1'b1; io_adr = a;
        @(negedge clk);
        io_re = 1'b0;
        d = io_rdata;
    endtask

    task automatic program_regs(input logic [15:0] adr, input logic [7:0] cnt_lo,
                                input logic [7:0] cnt_hi, input logic [7:0] mode);
        io_wr(2'd2, 8'h00);
        io_wr(2'd0, adr[7:0]);
        io_wr(2'd0, adr[15:8]);
        io_wr(2'd1, cnt_lo);
        io_wr(2'd1, cnt_hi);
        io_wr(2'd2, mode);
    endtask

    task automatic wait_dacks(input int target, input int budget);
        int n = 0;
        while (dack_cnt < target && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("dack_count_reached", 32'(dack_cnt >= target), 32'd1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    logic [7:0] rd, rd2;
    int base_cnt_at;

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        pipe[0] = 8'h00;

        #23;
        chk("rst_busreq", 32'(busreq), 0);
        chk("rst_dack", 32'(dack), 0);
        chk("rst_tc", 32'(tc), 0);
        chk("rst_io_rdata", 32'(io_rdata), 0);
        chk("rst_ram_adr", 32'(ram_adr), 0);
        @(negedge clk);
        reset_n = 1'b1;
        idle(2);

        // Autoload frame of 120 bytes.
        program_regs(16'hF300, 8'h77, 8'h00, 8'h81);
        push_range(16'hF300, 120, 0, 120);
        base_cnt_at = dack_cnt;
        drq = 1'b1;
        wait_dacks(base_cnt_at + 120, 2000);
        drq = 1'b0;
        idle(4);
        chk("t1_sb_empty", 32'(sb.size()), 0);
        io_rd(2'd2, rd);  chk("t1_status", 32'(rd), 32'h18);
        io_rd(2'd0, rd);  io_rd(2'd0, rd2);
        chk("t1_cur_adr", 32'({rd2, rd}), 32'hF300);
        io_rd(2'd1, rd);  io_rd(2'd1, rd2);
        chk("t1_cur_cnt", 32'({rd2, rd}), 32'h0077);

        // Same frame without autoload.
        io_wr(2'd2, 8'h00);
        io_wr(2'd2, 8'h01);
        push_range(16'hF300, 120, 0, 120);
        base_cnt_at = dack_cnt;
        drq = 1'b1;
        wait_dacks(base_cnt_at + 120, 2000);
        drq = 1'b0;
        idle(4);
        chk("t2_sb_empty", 32'(sb.size()), 0);
        io_rd(2'd2, rd);  chk("t2_status_first", 32'(rd), 32'h08);
        io_rd(2'd2, rd);  chk("t2_status_second", 32'(rd), 32'h00);
        drq = 1'b1;
        idle(20);
        chk("t2_no_busreq", 32'(busreq), 0);
        drq = 1'b0;

        // Drop drq after 10 bytes, then resume.
        io_wr(2'd2, 8'h01);
        push_range(16'hF300, 120, 0, 10);
        base_cnt_at = dack_cnt;
        drq = 1'b1;
        wait_dacks(base_cnt_at + 10, 500);
        drq = 1'b0;
        @(negedge clk);
        chk("t3_busreq_drop", 32'(busreq), 0);
        idle(5);
        chk("t3_exact_10", 32'(dack_cnt - base_cnt_at), 10);
        io_rd(2'd0, rd);  io_rd(2'd0, rd2);
        chk("t3_cur_adr", 32'({rd2, rd}), 32'hF30A);
        io_rd(2'd1, rd);  io_rd(2'd1, rd2);
        chk("t3_cur_cnt", 32'({rd2, rd}), 32'h006D);
        push_range(16'hF300, 120, 10, 120);
        drq = 1'b1;
        wait_dacks(base_cnt_at + 120, 2000);
        drq = 1'b0;
        idle(4);
        chk("t3_sb_empty", 32'(sb.size()), 0);
        io_rd(2'd2, rd);  chk("t3_status", 32'(rd), 32'h08);

        // Grant withdrawn during the address phase of byte 5.
        io_wr(2'd2, 8'h01);
        push_range(16'hF300, 120, 0, 120);
        base_cnt_at = dack_cnt;
        drq = 1'b1;
        wait_dacks(base_cnt_at + 4, 500);
        @(negedge clk);
        bus_hold = 1'b1;
        @(negedge clk);
        chk("t4_no_dack_on_loss", 32'(dack), 0);
        idle(3);
        chk("t4_held_count", 32'(dack_cnt - base_cnt_at), 4);
        bus_hold = 1'b0;
        wait_dacks(base_cnt_at + 120, 2000);
        drq = 1'b0;
        idle(4);
        chk("t4_sb_empty", 32'(sb.size()), 0);
        io_rd(2'd2, rd);  chk("t4_status", 32'(rd), 32'h08);

        // Address wrap, count high bits [7:6] ignored.
        program_regs(16'hFFFE, 8'h03, 8'hC0, 8'h01);
        push_range(16'hFFFE, 4, 0, 4);
        base_cnt_at = dack_cnt;
        drq = 1'b1;
        wait_dacks(base_cnt_at + 4, 200);
        drq = 1'b0;
        idle(4);
        chk("t5_sb_empty", 32'(sb.size()), 0);
        io_rd(2'd2, rd);  chk("t5_status", 32'(rd), 32'h08);

        // Random frames with random grant stalls.
        for (int it = 0; it < 6; it++) begin
            logic [15:0] b;
            int          c;
            logic        au;
            b  = 16'($urandom_range(0, 65535));
            c  = $urandom_range(0, 30);
            au = 1'($urandom_range(0, 1));
            program_regs(b, 8'(c), 8'h00, au ? 8'h81 : 8'h01);
            push_range(b, c + 1, 0, c + 1);
            base_cnt_at = dack_cnt;
            stall_en = 1'b1;
            drq = 1'b1;
            wait_dacks(base_cnt_at + c + 1, 1500);
            drq = 1'b0;
            stall_en = 1'b0;
            idle(4);
            chk("rnd_sb_empty", 32'(sb.size()), 0);
            io_rd(2'd2, rd);  chk("rnd_status", 32'(rd), au ? 32'h18 : 32'h08);
        end

        // Reset in the middle of a burst.
        program_regs(16'hF300, 8'h77, 8'h00, 8'h01);
        push_range(16'hF300, 120, 0, 120);
        base_cnt_at = dack_cnt;
        drq = 1'b1;
        wait_dacks(base_cnt_at + 7, 500);
        #1 reset_n = 1'b0;
        #1;
        chk("mid_rst_busreq", 32'(busreq), 0);
        chk("mid_rst_dack", 32'(dack), 0);
        chk("mid_rst_tc", 32'(tc), 0);
        chk("mid_rst_ram_adr", 32'(ram_adr), 0);
        sb.delete();
        @(negedge clk);
        reset_n = 1'b1;
        idle(20);
        chk("post_rst_no_busreq", 32'(busreq), 0);
        drq = 1'b0;
        io_rd(2'd2, rd);  chk("post_rst_status", 32'(rd), 32'h00);
        io_rd(2'd0, rd);  io_rd(2'd0, rd2);
        chk("post_rst_cur_adr", 32'({rd2, rd}), 32'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
